// File: rtl/shift_seq_pkg.sv
// Shared definitions for the multi-cycle shift unit: op encodings, FSM state
// encoding and a small direction helper.
package shift_seq_pkg;

  // aluc operation encodings
  localparam logic [1:0] OP_SRA = 2'b00;
  localparam logic [1:0] OP_SLA = 2'b01;
  localparam logic [1:0] OP_SRL = 2'b10;
  localparam logic [1:0] OP_SLL = 2'b11;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // SRA and SRL move bits toward the LSB; SLA and SLL toward the MSB.
  function automatic logic is_right(input logic [1:0] op);
    return (op == OP_SRA) || (op == OP_SRL);
  endfunction

endpackage

// File: rtl/shift_seq_step.sv
// Combinational single shift step: moves work by 1 bit, or by 4 bits when
// stride4 is set, in the direction and fill selected by op.
module shift_seq_step
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] work,
  input  logic [1:0]       op,
  input  logic             stride4,
  output logic [WIDTH-1:0] work_next
);

  logic [2:0] amt;

  // Select shift distance and direction; only SRA replicates the sign bit.
  always_comb begin
    amt = stride4 ? 3'd4 : 3'd1;
    if (is_right(op)) begin
      if (op == OP_SRA) begin
        work_next = WIDTH'($signed(work) >>> amt);
      end else begin
        work_next = work >> amt;
      end
    end else begin
      work_next = work << amt;
    end
  end

endmodule

// File: rtl/shift_seq32.sv
// Multi-cycle 32-bit shifter (SRA/SLA/SRL/SLL by 0..31) behind valid/ready
// handshakes. Optional macro SHIFT_SEQ_STRIDE4_EN lets each SHIFT cycle move
// 4 bits while at least 4 remain; results are unchanged, only latency drops.
module shift_seq32
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   b,
  input  logic [1:0]       aluc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c
);

  localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);
  localparam logic [SHW-1:0] CNT_FOUR = SHW'(4);

  logic [1:0]       state, state_nx;
  logic [WIDTH-1:0] work, work_nx;
  logic [SHW-1:0]   cnt, cnt_nx;
  logic [1:0]       op, op_nx;
  logic [WIDTH-1:0] c_nx;
  logic             stride4;
  logic [WIDTH-1:0] step_out;

`ifdef SHIFT_SEQ_STRIDE4_EN
  assign stride4 = (cnt >= CNT_FOUR);
`else
  assign stride4 = 1'b0;
`endif

  shift_seq_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .work      (work),
    .op        (op),
    .stride4   (stride4),
    .work_next (step_out)
  );

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  // Next-state: accept in IDLE, step until cnt hits zero, hold result in DONE.
  always_comb begin
    state_nx = state;
    work_nx  = work;
    cnt_nx   = cnt;
    op_nx    = op;
    c_nx     = c;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          work_nx = a;
          cnt_nx  = b;
          op_nx   = aluc;
          if (b == '0) begin
            c_nx     = a;
            state_nx = ST_DONE;
          end else begin
            state_nx = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        work_nx = step_out;
        cnt_nx  = cnt - (stride4 ? CNT_FOUR : CNT_ONE);
        if (cnt_nx == '0) begin
          c_nx     = step_out;
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any request in flight and clears the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      work  <= '0;
      cnt   <= '0;
      op    <= OP_SRA;
      c     <= '0;
    end else begin
      state <= state_nx;
      work  <= work_nx;
      cnt   <= cnt_nx;
      op    <= op_nx;
      c     <= c_nx;
    end
  end

endmodule

// File: tb/tb_shift_seq32.sv
// Self-checking bench for shift_seq32: directed cases plus randomized
// requests compared against an arithmetic reference model.
module tb_shift_seq32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [4:0]  b;
  logic [1:0]  aluc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] c;

  int n_checks;
  int n_fail;

  shift_seq32 #(
    .WIDTH (32),
    .SHW   (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .aluc      (aluc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] x, input int sh, input logic [1:0] op);
    case (op)
      2'b00:   return 32'($signed(x) >>> sh);
      2'b10:   return x >> sh;
      default: return x << sh;
    endcase
  endfunction

  function automatic int latency(input int sh);
`ifdef SHIFT_SEQ_STRIDE4_EN
    return sh / 4 + sh % 4;
`else
    return sh;
`endif
  endfunction

  // Issue one request, check latency and result, then hand off after `hold`
  // cycles of backpressure during which in_valid pulses must be ignored.
  task automatic run_op(input logic [31:0] av, input int sh, input logic [1:0] op,
                        input int hold);
    int k;
    logic [31:0] exp;
    exp = model(av, sh, op);
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 64) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_before_req", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a        = av;
    b        = 5'(sh);
    aluc     = op;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = 5'($urandom);
    aluc     = 2'($urandom);
    @(negedge clk);
    k = 0;
    while (!out_valid && k < 64) begin
      @(negedge clk);
      k++;
    end
    check("latency", 32'(k), 32'(latency(sh)));
    check("result", c, exp);
    check("in_ready_in_done", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a        = $urandom;
      b        = 5'($urandom);
      @(negedge clk);
      in_valid = 1'b0;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result", c, exp);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_after_handoff", 32'(out_valid), 32'd0);
    check("ready_after_handoff", 32'(in_ready), 32'd1);
    check("c_retained", c, exp);
  endtask

  initial begin
    int seen;
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    aluc      = '0;
    repeat (2) @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_c", c, 32'd0);
    rst_n = 1'b1;

    run_op(32'hA5A5A5A5, 1, 2'b00, 0);
    check("dir_sra", c, 32'hD2D2D2D2);
    run_op(32'hA5A5A5A5, 4, 2'b01, 1);
    check("dir_sla", c, 32'h5A5A5A50);
    run_op(32'h5A5A5A5A, 8, 2'b10, 0);
    check("dir_srl", c, 32'h005A5A5A);
    run_op(32'h5A5A5A5A, 2, 2'b11, 0);
    check("dir_sll", c, 32'h69696968);
    run_op(32'h12345678, 0, 2'b11, 0);
    check("dir_b0", c, 32'h12345678);
    run_op(32'h80000000, 31, 2'b00, 5);
    check("dir_bp_sra31", c, 32'hFFFFFFFF);

    for (int t = 0; t < 40; t++) begin
      run_op($urandom, int'($urandom_range(0, 31)), 2'($urandom), int'($urandom_range(0, 3)));
    end

    // Reset three cycles into a 20-bit shift.
    @(negedge clk);
    in_valid = 1'b1;
    a        = 32'hCAFEF00D;
    b        = 5'd20;
    aluc     = 2'b10;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midop_out_valid", 32'(out_valid), 32'd0);
    check("midop_c", c, 32'd0);
    check("midop_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_result_after_reset", 32'(seen), 32'd0);
    check("c_after_reset", c, 32'd0);
    out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
